// File: rtl/vending_change_dispenser.sv
`default_nettype none
// ============================================================================
//  Module   : vending_change_dispenser
//  Purpose  : Greedy coin-change sequencer driving a 5-denomination hopper bank
//             over valid/ack, with per-denomination inventory and fault fallback.
//  Revision : 1.0 - initial release
// ============================================================================
module vending_change_dispenser #(
    parameter int INV_W       = 8,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic             I_CLK,
    input  logic             I_RESET,
    input  logic             I_REQ,
    input  logic [15:0]      I_AMOUNT,
    input  logic             I_REFILL,
    input  logic [2:0]       I_REFILL_SEL,
    input  logic [INV_W-1:0] I_REFILL_CNT,
    input  logic             I_COIN_ACK,
    output logic             O_COIN_VALID,
    output logic [2:0]       O_COIN_SEL,
    output logic             O_BUSY,
    output logic             O_DONE,
    output logic             O_SHORT,
    output logic [15:0]      O_REMAIN,
    output logic [4:0]       O_INV_EMPTY
);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_SELECT = 2'd1;
    localparam logic [1:0] c_S_ISSUE  = 2'd2;
    localparam logic [1:0] c_S_FINISH = 2'd3;

    // Counter only has to reach ACK_TIMEOUT-1.
    localparam int              c_CNT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ACK_TIMEOUT - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [INV_W-1:0]   r_inv [5];
    logic [15:0]        r_remain;
    logic [2:0]         r_sel;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_short;
    logic               w_found;
    logic [2:0]         w_pick;
    logic               w_ack_hit;
    logic               w_timeout;

    function automatic logic [15:0] f_value(input logic [2:0] d);
        case (d)
            3'd0:    f_value = 16'd100;
            3'd1:    f_value = 16'd25;
            3'd2:    f_value = 16'd10;
            3'd3:    f_value = 16'd5;
            default: f_value = 16'd1;
        endcase
    endfunction

    // Scan from smallest coin upward so the last hit is the largest usable coin.
    always_comb begin
        w_found = 1'b0;
        w_pick  = 3'd0;
        for (int d = 4; d >= 0; d--) begin
            if ((r_inv[d] != '0) && (f_value(3'(d)) <= r_remain)) begin
                w_found = 1'b1;
                w_pick  = 3'(d);
            end
        end
    end

    assign w_ack_hit = (r_state == c_S_ISSUE) && I_COIN_ACK;
    assign w_timeout = (r_state == c_S_ISSUE) && !I_COIN_ACK && (r_cnt == c_CNT_LAST);

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) r_state <= c_S_IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE:   if (I_REQ) w_next_state = c_S_SELECT;
            c_S_SELECT: w_next_state = ((r_remain != 16'd0) && w_found) ? c_S_ISSUE : c_S_FINISH;
            c_S_ISSUE:  if (w_ack_hit || w_timeout) w_next_state = c_S_SELECT;
            default:    w_next_state = c_S_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            r_remain <= 16'd0;
            r_sel    <= 3'd0;
            r_cnt    <= '0;
            r_short  <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (I_REQ) begin
                        r_remain <= I_AMOUNT;
                        r_short  <= 1'b0;
                    end
                end
                c_S_SELECT: begin
                    if (r_remain == 16'd0) begin
                        r_short <= 1'b0;
                    end else if (w_found) begin
                        r_sel <= w_pick;
                        r_cnt <= '0;
                    end else begin
                        r_short <= 1'b1;
                    end
                end
                c_S_ISSUE: begin
                    if (w_ack_hit)       r_remain <= r_remain - f_value(r_sel);
                    else if (!w_timeout) r_cnt    <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Refill has priority; decrement saturates in case a refill zeroed the hopper mid-coin.
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            for (int d = 0; d < 5; d++) r_inv[d] <= '0;
        end else begin
            for (int d = 0; d < 5; d++) begin
                if (I_REFILL && (I_REFILL_SEL == 3'(d)))
                    r_inv[d] <= I_REFILL_CNT;
                else if (w_ack_hit && (r_sel == 3'(d)) && (r_inv[d] != '0))
                    r_inv[d] <= r_inv[d] - 1'b1;
                else if (w_timeout && (r_sel == 3'(d)))
                    r_inv[d] <= '0;
            end
        end
    end

    always_comb begin
        O_BUSY       = (r_state != c_S_IDLE);
        O_COIN_VALID = (r_state == c_S_ISSUE);
        O_DONE       = (r_state == c_S_FINISH);
        O_COIN_SEL   = r_sel;
        O_SHORT      = r_short;
        O_REMAIN     = r_remain;
        for (int d = 0; d < 5; d++) O_INV_EMPTY[d] = (r_inv[d] == '0);
    end

endmodule
`default_nettype wire

// File: tb/tb_vending_change_dispenser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vending_change_dispenser
//  Purpose  : Directed self-checking bench for vending_change_dispenser.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vending_change_dispenser;

    localparam int c_INV_W = 8;
    localparam int c_TMO   = 4;

    logic               I_CLK;
    logic               I_RESET;
    logic               I_REQ;
    logic [15:0]        I_AMOUNT;
    logic               I_REFILL;
    logic [2:0]         I_REFILL_SEL;
    logic [c_INV_W-1:0] I_REFILL_CNT;
    logic               I_COIN_ACK;
    logic               O_COIN_VALID;
    logic [2:0]         O_COIN_SEL;
    logic               O_BUSY;
    logic               O_DONE;
    logic               O_SHORT;
    logic [15:0]        O_REMAIN;
    logic [4:0]         O_INV_EMPTY;

    int checks = 0;
    int errors = 0;

    vending_change_dispenser #(.INV_W(c_INV_W), .ACK_TIMEOUT(c_TMO)) dut (
        .I_CLK(I_CLK), .I_RESET(I_RESET), .I_REQ(I_REQ), .I_AMOUNT(I_AMOUNT),
        .I_REFILL(I_REFILL), .I_REFILL_SEL(I_REFILL_SEL), .I_REFILL_CNT(I_REFILL_CNT),
        .I_COIN_ACK(I_COIN_ACK), .O_COIN_VALID(O_COIN_VALID), .O_COIN_SEL(O_COIN_SEL),
        .O_BUSY(O_BUSY), .O_DONE(O_DONE), .O_SHORT(O_SHORT), .O_REMAIN(O_REMAIN),
        .O_INV_EMPTY(O_INV_EMPTY)
    );

    initial I_CLK = 1'b0;
    always #5 I_CLK = ~I_CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge I_CLK);
        #1;
    endtask

    task automatic refill(input logic [2:0] sel, input logic [c_INV_W-1:0] cnt);
        I_REFILL = 1'b1; I_REFILL_SEL = sel; I_REFILL_CNT = cnt;
        tick();
        I_REFILL = 1'b0;
    endtask

    task automatic refill_all(input logic [c_INV_W-1:0] c0, c1, c2, c3, c4);
        refill(3'd0, c0); refill(3'd1, c1); refill(3'd2, c2); refill(3'd3, c3); refill(3'd4, c4);
    endtask

    task automatic request(input logic [15:0] amt);
        I_REQ = 1'b1; I_AMOUNT = amt;
        tick();
        I_REQ = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && !O_COIN_VALID; i++) tick();
        chk({tag, "_valid"}, 32'(O_COIN_VALID), 32'd1);
    endtask

    // Waits for a coin request, checks its denomination, acks it for one cycle.
    task automatic expect_coin(input string tag, input logic [2:0] sel);
        wait_valid(tag);
        chk({tag, "_sel"}, 32'(O_COIN_SEL), 32'(sel));
        I_COIN_ACK = 1'b1;
        tick();
        I_COIN_ACK = 1'b0;
        chk({tag, "_drop"}, 32'(O_COIN_VALID), 32'd0);
    endtask

    task automatic expect_done(input string tag, input logic short_exp, input logic [15:0] rem_exp);
        for (int i = 0; i < 20 && !O_DONE; i++) begin
            chk({tag, "_novalid"}, 32'(O_COIN_VALID), 32'd0);
            tick();
        end
        chk({tag, "_done"}, 32'(O_DONE), 32'd1);
        chk({tag, "_short"}, 32'(O_SHORT), 32'(short_exp));
        chk({tag, "_remain"}, 32'(O_REMAIN), 32'(rem_exp));
        tick();
        chk({tag, "_done_pulse"}, 32'(O_DONE), 32'd0);
        chk({tag, "_idle"}, 32'(O_BUSY), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt;
        I_RESET = 1'b1; I_REQ = 1'b0; I_AMOUNT = '0; I_REFILL = 1'b0;
        I_REFILL_SEL = '0; I_REFILL_CNT = '0; I_COIN_ACK = 1'b0;
        #3;
        chk("rst_valid", 32'(O_COIN_VALID), 32'd0);
        chk("rst_busy",  32'(O_BUSY), 32'd0);
        chk("rst_done",  32'(O_DONE), 32'd0);
        chk("rst_short", 32'(O_SHORT), 32'd0);
        chk("rst_remain", 32'(O_REMAIN), 32'd0);
        chk("rst_sel",   32'(O_COIN_SEL), 32'd0);
        chk("rst_empty", 32'(O_INV_EMPTY), 32'h1F);
        tick();
        I_RESET = 1'b0;
        tick();

        // 290 cents: 100,100,25,25,25,10,5
        refill_all(8'd10, 8'd10, 8'd10, 8'd10, 8'd10);
        chk("t1_empty_pre", 32'(O_INV_EMPTY), 32'h00);
        request(16'd290);
        chk("t1_busy", 32'(O_BUSY), 32'd1);
        expect_coin("t1_c0", 3'd0);
        expect_coin("t1_c1", 3'd0);
        expect_coin("t1_c2", 3'd1);
        expect_coin("t1_c3", 3'd1);
        expect_coin("t1_c4", 3'd1);
        expect_coin("t1_c5", 3'd2);
        expect_coin("t1_c6", 3'd3);
        expect_done("t1", 1'b0, 16'd0);
        chk("t1_empty_post", 32'(O_INV_EMPTY), 32'h00);

        // No quarters: 30 cents as three dimes
        refill_all(8'd10, 8'd0, 8'd10, 8'd10, 8'd10);
        request(16'd30);
        expect_coin("t2_c0", 3'd2);
        expect_coin("t2_c1", 3'd2);
        expect_coin("t2_c2", 3'd2);
        expect_done("t2", 1'b0, 16'd0);

        // Only two pennies for 7 cents: shortfall of 5
        refill_all(8'd0, 8'd0, 8'd0, 8'd0, 8'd2);
        request(16'd7);
        expect_coin("t3_c0", 3'd4);
        expect_coin("t3_c1", 3'd4);
        expect_done("t3", 1'b1, 16'd5);
        chk("t3_empty", 32'(O_INV_EMPTY), 32'h1F);

        // Dollar hopper never acks: faulted after ACK_TIMEOUT cycles, then quarters
        refill_all(8'd10, 8'd10, 8'd0, 8'd0, 8'd0);
        request(16'd100);
        wait_valid("t4_fault");
        chk("t4_fault_sel", 32'(O_COIN_SEL), 32'd0);
        vcnt = 0;
        while (O_COIN_VALID && vcnt < 20) begin
            vcnt++;
            tick();
        end
        chk("t4_valid_cycles", 32'(vcnt), 32'(c_TMO));
        chk("t4_empty0", 32'(O_INV_EMPTY[0]), 32'd1);
        expect_coin("t4_c0", 3'd1);
        expect_coin("t4_c1", 3'd1);
        expect_coin("t4_c2", 3'd1);
        expect_coin("t4_c3", 3'd1);
        expect_done("t4", 1'b0, 16'd0);
        chk("t4_empty_post", 32'(O_INV_EMPTY), 32'b11101);

        // Asynchronous reset while a coin is outstanding
        refill(3'd0, 8'd10);
        request(16'd100);
        wait_valid("t5");
        #2;
        I_RESET = 1'b1;
        #1;
        chk("t5_valid", 32'(O_COIN_VALID), 32'd0);
        chk("t5_busy",  32'(O_BUSY), 32'd0);
        chk("t5_remain", 32'(O_REMAIN), 32'd0);
        chk("t5_short", 32'(O_SHORT), 32'd0);
        chk("t5_empty", 32'(O_INV_EMPTY), 32'h1F);
        tick();
        I_RESET = 1'b0;
        tick();
        request(16'd100);
        expect_done("t5_after", 1'b1, 16'd100);

        // Zero amount; a second request while busy must be ignored
        I_REQ = 1'b1; I_AMOUNT = 16'd0;
        tick();
        I_AMOUNT = 16'd50;
        chk("t6_busy", 32'(O_BUSY), 32'd1);
        chk("t6_nodone", 32'(O_DONE), 32'd0);
        chk("t6_novalid", 32'(O_COIN_VALID), 32'd0);
        tick();
        I_REQ = 1'b0;
        chk("t6_done", 32'(O_DONE), 32'd1);
        chk("t6_short", 32'(O_SHORT), 32'd0);
        chk("t6_remain", 32'(O_REMAIN), 32'd0);
        chk("t6_novalid2", 32'(O_COIN_VALID), 32'd0);
        tick();
        chk("t6_done_pulse", 32'(O_DONE), 32'd0);
        chk("t6_idle", 32'(O_BUSY), 32'd0);
        tick();
        chk("t6_still_idle", 32'(O_BUSY), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
